dac_cmd_rx: RTL and testbench
=============================

// Module: dac_cmd_rx
// PURPOSE
//  UART command receiver and frame decoder. It drives the DAC controller's control inputs:
//  signal_select, clk_select and ctl_data_val.
//  It deserialises 8N1 bytes from the host and hunts for a 5-byte command frame.
//  It validates the frame, then updates all three control outputs atomically on one clock edge.
//  It runs on the DAC clock domain, so the outputs need no CDC in the consumer.
// PARAMETERS
//  CLKS_PER_BIT  434    dac_clk_in cycles per UART bit (50 MHz / 115200); minimum 8
//  TIMEOUT_BITS  32     idle bit-times allowed between bytes inside a frame before abort
// PORTS
//  dac_clk_in     in   1  system/DAC clock; all logic on its rising edge
//  reset_n        in   1  asynchronous active-low reset
//  uart_rxd       in   1  asynchronous serial input, idle high
//  signal_select  out  8  phase-step / waveform select to DAC controller
//  clk_select     out  8  output clock-rate code, 0x20..0x24
//  ctl_data_val   out  1  DAC run enable (1 = stream samples)
//  frame_ok       out  1  1-cycle pulse: valid frame applied
//  frame_err      out  1  1-cycle pulse: frame rejected (checksum/range/stop-bit/timeout)
// BEHAVIOUR
//  Reset values: signal_select=8'h01, clk_select=8'h20, ctl_data_val=0, frame_ok=0,
//   frame_err=0, parser=HUNT, bit engine=IDLE.
//  Input path: 2-FF synchroniser on uart_rxd. All decoding uses the synchronised signal.
//  Bit engine (IDLE, START, DATA, STOP):
//   IDLE->START on a synchronised high->low transition.
//   START: at CLKS_PER_BIT/2 re-sample. If low, go to DATA; if high (glitch), go back to IDLE, no error.
//   DATA: sample every CLKS_PER_BIT, 8 bits, LSB first.
//   STOP: sample once at mid-bit. If 1, byte_valid pulses 1 cycle. If 0, framing error.
//   After STOP, return to IDLE immediately. A new start edge is accepted in the same cycle.
//  Frame: 0xAA, CLK, SIG, CTL, SUM, where SUM = CLK ^ SIG ^ CTL.
//  Parser states: HUNT, GET_CLK, GET_SIG, GET_CTL, GET_SUM.
//   HUNT: byte 0xAA -> GET_CLK; any other byte is ignored silently.
//   Each subsequent valid byte is stored and advances the state.
//   In GET_SUM, the byte is checked; parser always returns to HUNT afterwards.
//  Acceptance in GET_SUM requires all of:
//   - SUM matches
//   - CLK in 0x20..0x24
//   - SIG != 0x00
//   - CTL in {0x00, 0x01}
//  On acceptance: on the edge after byte_valid, outputs load CLK, SIG and CTL[0] together and
//   frame_ok pulses. No output ever shows a mix of old and new frame values.
//  On rejection: outputs hold, frame_err pulses, parser -> HUNT.
//  A framing error in any non-HUNT state: frame_err, -> HUNT. In HUNT: ignored, no pulse.
//  Timeout: in GET_CLK..GET_SUM, a counter resets on every byte_valid.
//   At TIMEOUT_BITS*CLKS_PER_BIT idle cycles: frame_err, -> HUNT.
//  0xAA received mid-frame is treated as data, not as a resync.
//  Latency: outputs update 1 dac_clk_in cycle after the SUM stop-bit sample.
//  Reset asserted mid-byte or mid-frame: everything returns to reset values immediately.
//   After release, the engine waits for a fresh falling edge. A partial frame is never completed.
//  frame_ok and frame_err are never high in the same cycle.
//  Counters are sized with $clog2 of their terminal values. No counter wraps silently.
// TESTING
//  1 Reset release, rxd idle -> outputs 01/20/0, no pulses for 10 bit-times.
//  2 Send AA 22 05 01 26 -> clk_select=22, signal_select=05, ctl_data_val=1.
//    frame_ok pulses exactly once, 1 cycle after SUM stop sample.
//  3 Send AA 22 05 01 27 (bad sum) -> frame_err pulse, outputs unchanged.
//    Send AA 25 05 01 21 -> frame_err (CLK range). Send AA 20 00 00 20 -> frame_err (SIG=0).
//  4 Send AA 21 then 40 bit-times idle -> frame_err at 32 bit-times.
//    Then AA 24 10 00 34 -> applied: 24/10/0.
//  5 Stop bit forced 0 on the SIG byte -> frame_err, HUNT.
//    Next good frame accepted. 1/4-bit low glitch on idle line -> no byte, no pulse.
//  6 Assert reset_n low during the CTL byte of a valid frame -> reset values.
//    Post-release, remaining bits produce no frame_ok. Back-to-back frames with no idle gap
//    -> both applied.

Source files
------------

// File: rtl/dac_cmd_rx.sv
// UART 8N1 command receiver for the DAC controller: deserialises host bytes, decodes the
// 5-byte frame AA/CLK/SIG/CTL/SUM and applies validated settings atomically.
module dac_cmd_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic       dac_clk_in,
  input  logic       reset_n,
  input  logic       uart_rxd,
  output logic [7:0] signal_select,
  output logic [7:0] clk_select,
  output logic       ctl_data_val,
  output logic       frame_ok,
  output logic       frame_err
);

  localparam int HALF_BIT       = CLKS_PER_BIT / 2;
  localparam int BIT_CNT_W      = $clog2(CLKS_PER_BIT);
  localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_CNT_W       = $clog2(TIMEOUT_CYCLES);

  localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_CNT_W-1:0] HALF_LAST = BIT_CNT_W'(HALF_BIT - 1);
  localparam logic [TO_CNT_W-1:0]  TO_LAST   = TO_CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } bit_state_t;

  typedef enum logic [2:0] {
    P_HUNT,
    P_GET_CLK,
    P_GET_SIG,
    P_GET_CTL,
    P_GET_SUM
  } parse_state_t;

  logic                 rxd_meta;
  logic                 rxd_sync;
  logic                 rxd_prev;
  logic                 start_edge;

  bit_state_t           bit_state;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [2:0]           bit_idx;
  logic [7:0]           shift_reg;
  logic                 byte_valid;
  logic                 framing_err;

  parse_state_t         parse_state;
  logic [TO_CNT_W-1:0]  to_cnt;
  logic [7:0]           clk_byte;
  logic [7:0]           sig_byte;
  logic [7:0]           ctl_byte;
  logic                 frame_good;

  // Synchroniser resets low so a line that is low when reset releases never looks like a
  // start edge; the engine only arms on a genuine high->low transition.
  always_ff @(posedge dac_clk_in or negedge reset_n) begin
    if (!reset_n) begin
      rxd_meta <= 1'b0;
      rxd_sync <= 1'b0;
      rxd_prev <= 1'b0;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  assign start_edge = rxd_prev & ~rxd_sync;

  always_ff @(posedge dac_clk_in or negedge reset_n) begin
    if (!reset_n) begin
      bit_state   <= B_IDLE;
      bit_cnt     <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
      unique case (bit_state)
        B_IDLE: begin
          bit_cnt <= '0;
          bit_idx <= '0;
          if (start_edge) bit_state <= B_START;
        end
        B_START: begin
          if (bit_cnt == HALF_LAST) begin
            bit_cnt   <= '0;
            bit_state <= rxd_sync ? B_IDLE : B_DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        B_DATA: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt   <= '0;
            shift_reg <= {rxd_sync, shift_reg[7:1]};
            if (bit_idx == 3'd7) begin
              bit_state <= B_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        B_STOP: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt     <= '0;
            bit_idx     <= '0;
            byte_valid  <= rxd_sync;
            framing_err <= ~rxd_sync;
            bit_state   <= start_edge ? B_START : B_IDLE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: bit_state <= B_IDLE;
      endcase
    end
  end

  // The incoming byte is the checksum; the stored fields must also be in range.
  assign frame_good = (shift_reg == (clk_byte ^ sig_byte ^ ctl_byte)) &&
                      (clk_byte >= 8'h20) && (clk_byte <= 8'h24) &&
                      (sig_byte != 8'h00) &&
                      (ctl_byte[7:1] == 7'd0);

  always_ff @(posedge dac_clk_in or negedge reset_n) begin
    if (!reset_n) begin
      parse_state   <= P_HUNT;
      to_cnt        <= '0;
      clk_byte      <= '0;
      sig_byte      <= '0;
      ctl_byte      <= '0;
      signal_select <= 8'h01;
      clk_select    <= 8'h20;
      ctl_data_val  <= 1'b0;
      frame_ok      <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      if (parse_state == P_HUNT) begin
        to_cnt <= '0;
        if (byte_valid && (shift_reg == 8'hAA)) parse_state <= P_GET_CLK;
      end else if (framing_err) begin
        frame_err   <= 1'b1;
        parse_state <= P_HUNT;
      end else if (byte_valid) begin
        to_cnt <= '0;
        unique case (parse_state)
          P_GET_CLK: begin
            clk_byte    <= shift_reg;
            parse_state <= P_GET_SIG;
          end
          P_GET_SIG: begin
            sig_byte    <= shift_reg;
            parse_state <= P_GET_CTL;
          end
          P_GET_CTL: begin
            ctl_byte    <= shift_reg;
            parse_state <= P_GET_SUM;
          end
          P_GET_SUM: begin
            if (frame_good) begin
              clk_select    <= clk_byte;
              signal_select <= sig_byte;
              ctl_data_val  <= ctl_byte[0];
              frame_ok      <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            parse_state <= P_HUNT;
          end
          default: parse_state <= P_HUNT;
        endcase
      end else if (to_cnt == TO_LAST) begin
        frame_err   <= 1'b1;
        parse_state <= P_HUNT;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dac_cmd_rx.sv
// Directed bench for dac_cmd_rx: drives 8N1 frames on uart_rxd and checks the applied
// settings, pulse counts and pulse timing against hand-computed values.
module tb_dac_cmd_rx;

  localparam int CPB = 16;
  localparam int TOB = 32;
  // Stop-bit mid-sample sits 9.5 bit-times after the start edge, plus a few sync cycles.
  localparam int SUM_LAT_LO = 9 * CPB + CPB / 2;
  localparam int SUM_LAT_HI = SUM_LAT_LO + 6;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       uart_rxd;
  logic [7:0] signal_select;
  logic [7:0] clk_select;
  logic       ctl_data_val;
  logic       frame_ok;
  logic       frame_err;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int ok_cnt = 0;
  int err_cnt = 0;
  int last_ok_cyc = 0;
  int last_err_cyc = 0;
  int last_start_cyc = 0;
  int both_high = 0;
  int mix_seen = 0;
  logic [16:0] prev_out = 17'h0;

  dac_cmd_rx #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .dac_clk_in   (clk),
    .reset_n      (reset_n),
    .uart_rxd     (uart_rxd),
    .signal_select(signal_select),
    .clk_select   (clk_select),
    .ctl_data_val (ctl_data_val),
    .frame_ok     (frame_ok),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Pulse bookkeeping; outputs may only move in the cycle frame_ok is high.
  always @(negedge clk) begin
    if (frame_ok) begin
      ok_cnt++;
      last_ok_cyc = cyc;
    end
    if (frame_err) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
    if (frame_ok && frame_err) both_high = 1;
    if (reset_n && !frame_ok && ({clk_select, signal_select, ctl_data_val} !== prev_out))
      mix_seen = 1;
    prev_out = {clk_select, signal_select, ctl_data_val};
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("[TB] check %s did not match", tag);
    end
  endtask

  // Sends one byte starting at a falling clock edge; optionally pulses reset mid-bit.
  task automatic apply_stimulus(input logic [7:0] b, input logic stop_bit, input int rst_at_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rxd = bits[i];
      if (i == 0) last_start_cyc = cyc;
      if (i == rst_at_bit) begin
        repeat (CPB / 2) @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (CPB - CPB / 2 - 3) @(negedge clk);
      end else begin
        repeat (CPB) @(negedge clk);
      end
    end
    uart_rxd = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] s, input logic [7:0] t,
                            input logic [7:0] sum);
    apply_stimulus(8'hAA, 1'b1, -1);
    apply_stimulus(c, 1'b1, -1);
    apply_stimulus(s, 1'b1, -1);
    apply_stimulus(t, 1'b1, -1);
    apply_stimulus(sum, 1'b1, -1);
  endtask

  initial begin
    int start21;
    reset_n  = 1'b0;
    uart_rxd = 1'b1;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] reset release, idle line");
    repeat (10 * CPB) @(negedge clk);
    check_output("reset_outputs", {clk_select, signal_select, ctl_data_val}, {8'h20, 8'h01, 1'b0});
    check_output("reset_no_ok", ok_cnt, 0);
    check_output("reset_no_err", err_cnt, 0);

    $display("[TB] good frame AA 22 05 01 26");
    send_frame(8'h22, 8'h05, 8'h01, 8'h26);
    check_output("good_clk", clk_select, 8'h22);
    check_output("good_sig", signal_select, 8'h05);
    check_output("good_ctl", ctl_data_val, 1'b1);
    check_output("good_ok_once", ok_cnt, 1);
    check_output("good_latency", ((last_ok_cyc - last_start_cyc) >= SUM_LAT_LO) &&
                                 ((last_ok_cyc - last_start_cyc) <= SUM_LAT_HI), 1);

    $display("[TB] rejected frames");
    send_frame(8'h22, 8'h05, 8'h01, 8'h27);
    check_output("bad_sum_err", err_cnt, 1);
    send_frame(8'h25, 8'h05, 8'h01, 8'h21);
    check_output("clk_range_err", err_cnt, 2);
    send_frame(8'h20, 8'h00, 8'h00, 8'h20);
    check_output("sig_zero_err", err_cnt, 3);
    send_frame(8'h21, 8'h05, 8'h02, 8'h26);
    check_output("ctl_range_err", err_cnt, 4);
    check_output("reject_hold", {clk_select, signal_select, ctl_data_val}, {8'h22, 8'h05, 1'b1});
    check_output("reject_no_ok", ok_cnt, 1);

    $display("[TB] inter-byte timeout");
    apply_stimulus(8'hAA, 1'b1, -1);
    apply_stimulus(8'h21, 1'b1, -1);
    start21 = last_start_cyc;
    repeat (40 * CPB) @(negedge clk);
    check_output("timeout_err", err_cnt, 5);
    check_output("timeout_time", ((last_err_cyc - start21) >= SUM_LAT_LO + TOB * CPB - 2) &&
                                 ((last_err_cyc - start21) <= SUM_LAT_HI + TOB * CPB + 2), 1);
    send_frame(8'h24, 8'h10, 8'h00, 8'h34);
    check_output("after_timeout", {clk_select, signal_select, ctl_data_val}, {8'h24, 8'h10, 1'b0});
    check_output("after_timeout_ok", ok_cnt, 2);

    $display("[TB] stop bit low on SIG byte");
    apply_stimulus(8'hAA, 1'b1, -1);
    apply_stimulus(8'h22, 1'b1, -1);
    apply_stimulus(8'h05, 1'b0, -1);
    repeat (CPB) @(negedge clk);
    check_output("framing_err", err_cnt, 6);
    check_output("framing_hold", {clk_select, signal_select, ctl_data_val}, {8'h24, 8'h10, 1'b0});
    send_frame(8'h21, 8'h0F, 8'h01, 8'h2F);
    check_output("after_framing", {clk_select, signal_select, ctl_data_val}, {8'h21, 8'h0F, 1'b1});
    check_output("after_framing_ok", ok_cnt, 3);

    $display("[TB] quarter-bit glitch on idle line");
    uart_rxd = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    check_output("glitch_counts", {ok_cnt[15:0], err_cnt[15:0]}, {16'd3, 16'd6});
    check_output("glitch_hold", {clk_select, signal_select, ctl_data_val}, {8'h21, 8'h0F, 1'b1});

    $display("[TB] reset during CTL byte");
    apply_stimulus(8'hAA, 1'b1, -1);
    apply_stimulus(8'h22, 1'b1, -1);
    apply_stimulus(8'h05, 1'b1, -1);
    apply_stimulus(8'h01, 1'b1, 4);
    check_output("midreset_outputs", {clk_select, signal_select, ctl_data_val}, {8'h20, 8'h01, 1'b0});
    apply_stimulus(8'h26, 1'b1, -1);
    repeat (2 * CPB) @(negedge clk);
    check_output("midreset_no_ok", ok_cnt, 3);
    check_output("midreset_no_err", err_cnt, 6);
    check_output("midreset_hold", {clk_select, signal_select, ctl_data_val}, {8'h20, 8'h01, 1'b0});

    $display("[TB] back-to-back frames");
    send_frame(8'h23, 8'h07, 8'h01, 8'h25);
    check_output("b2b_first", {clk_select, signal_select, ctl_data_val}, {8'h23, 8'h07, 1'b1});
    send_frame(8'h20, 8'h03, 8'h00, 8'h23);
    check_output("b2b_second", {clk_select, signal_select, ctl_data_val}, {8'h20, 8'h03, 1'b0});
    check_output("b2b_ok", ok_cnt, 5);

    repeat (4) @(negedge clk);
    check_output("never_both_high", both_high, 0);
    check_output("atomic_update", mix_seen, 0);
    check_output("final_err", err_cnt, 6);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
